// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: request front end for a 512 x 48 two-port SRAM.
// A 4-entry request FIFO feeds a single issue stage that drives
// registered SRAM signals. Reads are captured into a 2-entry response
// buffer the cycle after they issue. A read issues only when the
// response buffer has guaranteed room for its data. Writes always issue.
// Requests stay in strict order, so a blocked read also holds back
// every request queued behind it.
// Optional feature: define SRAM_CTRL_STATS_EN to enable the saturating
// issued-read and issued-write counters. When it is not defined, the
// stat outputs are tied to zero.
module sram_req_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [8:0]  req_addr,
    input  logic [47:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [47:0] resp_data,
    output logic        sram_we,
    output logic [8:0]  sram_waddr,
    output logic [47:0] sram_wdata,
    output logic [8:0]  sram_raddr,
    input  logic [47:0] sram_rdata,
    output logic [15:0] stat_rd_count,
    output logic [15:0] stat_wr_count
);

    // Request FIFO storage and bookkeeping
    logic        fifo_write [4];
    logic [8:0]  fifo_addr  [4];
    logic [47:0] fifo_wdata [4];
    logic [1:0]  fifo_wr_ptr;
    logic [1:0]  fifo_rd_ptr;
    logic [2:0]  fifo_count;

    // Response buffer storage and bookkeeping
    logic [47:0] resp_mem [2];
    logic        resp_wr_ptr;
    logic        resp_rd_ptr;
    logic [1:0]  resp_count;

    // Set while sram_raddr carries a read whose data must be captured
    logic        read_inflight;

    logic        push;
    logic        head_write;
    logic        read_room;
    logic        pop;
    logic        issue_read;
    logic        issue_write;
    logic        resp_pop;

    assign req_ready   = (fifo_count < 3'd4);
    assign push        = req_valid & req_ready;
    assign head_write  = fifo_write[fifo_rd_ptr];
    // The response count plus the single possible in-flight read bounds
    // the entries the buffer may need to hold.
    assign read_room   = ((resp_count + {1'b0, read_inflight}) < 2'd2);
    assign pop         = (fifo_count != 3'd0) && (head_write || read_room);
    assign issue_read  = pop & ~head_write;
    assign issue_write = pop & head_write;

    assign resp_valid  = (resp_count != 2'd0);
    assign resp_data   = resp_valid ? resp_mem[resp_rd_ptr] : 48'd0;
    assign resp_pop    = resp_valid & resp_ready;

    // Request FIFO payload: write the tail entry on every accepted request
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_write[fifo_wr_ptr] <= req_write;
            fifo_addr[fifo_wr_ptr]  <= req_addr;
            fifo_wdata[fifo_wr_ptr] <= req_wdata;
        end
    end

    // Request FIFO pointers and occupancy; a push and pop together leave the count alone
    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_wr_ptr <= 2'd0;
            fifo_rd_ptr <= 2'd0;
            fifo_count  <= 3'd0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= fifo_wr_ptr + 2'd1;
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue stage: load the popped head into the registered SRAM signals
    always_ff @(posedge clock) begin
        if (reset) begin
            sram_we       <= 1'b0;
            sram_waddr    <= 9'd0;
            sram_wdata    <= 48'd0;
            sram_raddr    <= 9'd0;
            read_inflight <= 1'b0;
        end else begin
            sram_we       <= issue_write;
            read_inflight <= issue_read;
            if (issue_write) begin
                sram_waddr <= fifo_addr[fifo_rd_ptr];
                sram_wdata <= fifo_wdata[fifo_rd_ptr];
            end
            if (issue_read) begin
                sram_raddr <= fifo_addr[fifo_rd_ptr];
            end
        end
    end

    // Response buffer payload: capture SRAM read data at the end of the read cycle
    always_ff @(posedge clock) begin
        if (!reset && read_inflight) begin
            resp_mem[resp_wr_ptr] <= sram_rdata;
        end
    end

    // Response buffer pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_wr_ptr <= 1'b0;
            resp_rd_ptr <= 1'b0;
            resp_count  <= 2'd0;
        end else begin
            if (read_inflight) begin
                resp_wr_ptr <= ~resp_wr_ptr;
            end
            if (resp_pop) begin
                resp_rd_ptr <= ~resp_rd_ptr;
            end
            case ({read_inflight, resp_pop})
                2'b10:   resp_count <= resp_count + 2'd1;
                2'b01:   resp_count <= resp_count - 2'd1;
                default: resp_count <= resp_count;
            endcase
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    // Saturating counters of issued reads and writes
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (issue_read && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if (issue_write && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    assign stat_rd_count = rd_count;
    assign stat_wr_count = wr_count;
`else
    assign stat_rd_count = 16'd0;
    assign stat_wr_count = 16'd0;
`endif

endmodule
